// File: rtl/button_event.sv
// Turns one debounced button level into press/release/short/long/repeat event pulses.
// Optional auto-repeat in the long-press state is built only when BUTTON_EVENT_REPEAT_EN is defined.
// The release event appears on release_pulse because "release" is a reserved word in SystemVerilog.
module button_event #(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned CNT_BITS      = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam longint unsigned CNT_RANGE = 64'd1 << CNT_BITS;
  localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2) begin : g_chk_long
    $error("button_event: LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_chk_repeat
    $error("button_event: REPEAT_CYCLES must be at least 1");
  end
  if (64'(LONG_CYCLES) > CNT_RANGE || 64'(REPEAT_CYCLES) > CNT_RANGE) begin : g_chk_width
    $error("button_event: CNT_BITS too narrow for the configured thresholds");
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG
  } state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic                prev;
  logic                act;

  assign act = btn_in ^ ACTIVE_LOW;

  // prev resets to 1 so a button held through reset must be released before it can press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      prev          <= 1'b1;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      prev          <= act;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (act && !prev) begin
            state   <= ST_PRESSED;
            pressed <= 1'b1;
            press   <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (!act) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state      <= ST_LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end

        ST_LONG: begin
          if (!act) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
            if (cnt == REPEAT_LAST) begin
              cnt          <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_BITS'(1);
            end
`else
            cnt <= '0;
`endif
          end
        end

        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 3;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_REP   = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  logic btn_a, btn_b;
  logic pressed_a, press_a, release_a, short_a, long_a, repeat_a;
  logic pressed_b, press_b, release_b, short_b, long_b, repeat_b;

  button_event #(
    .ACTIVE_LOW   (1'b1),
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_BITS     (4)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_a),
    .pressed      (pressed_a),
    .press        (press_a),
    .release_pulse(release_a),
    .short_press  (short_a),
    .long_press   (long_a),
    .repeat_pulse (repeat_a)
  );

  button_event #(
    .ACTIVE_LOW   (1'b0),
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_BITS     (4)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_b),
    .pressed      (pressed_b),
    .press        (press_b),
    .release_pulse(release_b),
    .short_press  (short_b),
    .long_press   (long_b),
    .repeat_pulse (repeat_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
    logic       pr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input int d, input int c, input logic [4:0] ev, input logic pr);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    e.pr  = pr;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic check(input int d, input logic [4:0] ev, input logic pr);
    exp_t e;
    tests++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      fails++;
      $display("FAIL unexpected_event dut%0d cyc=%0d got ev=%b pressed=%b, required no event",
               d, cyc, ev, pr);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else        e = qb.pop_front();
    if (e.cyc != cyc || e.ev != ev || e.pr !== pr) begin
      fails++;
      $display("FAIL event dut%0d got cyc=%0d ev=%b pressed=%b, required cyc=%0d ev=%b pressed=%b",
               d, cyc, ev, pr, e.cyc, e.ev, e.pr);
    end
  endtask

  // Monitor: any event pulse or change of pressed is one observed transaction.
  logic       last_a = 1'b0;
  logic       last_b = 1'b0;
  logic [4:0] ev_a, ev_b;
  always @(negedge clk) begin
    ev_a = {press_a, release_a, short_a, long_a, repeat_a};
    ev_b = {press_b, release_b, short_b, long_b, repeat_b};
    if (ev_a != 5'b0 || pressed_a != last_a) check(0, ev_a, pressed_a);
    if (ev_b != 5'b0 || pressed_b != last_b) check(1, ev_b, pressed_b);
    last_a = pressed_a;
    last_b = pressed_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_act(input int d, input logic a);
    if (d == 0) btn_a = ~a;
    else        btn_b = a;
  endtask

  // Hold for n cycles then release and stay idle for gap cycles; expectations pushed up front.
  task automatic hold(input int d, input int n, input int gap);
    int s;
    s = cyc;
    push(d, s + 1, EV_PRESS, 1'b1);
    if (n >= L + 1) begin
      push(d, s + 1 + L, EV_LONG, 1'b1);
`ifdef BUTTON_EVENT_REPEAT_EN
      for (int e = s + 1 + L + R; e <= s + n; e += R) push(d, e, EV_REP, 1'b1);
`endif
      push(d, s + n + 1, EV_REL, 1'b0);
    end else begin
      push(d, s + n + 1, EV_REL | EV_SHORT, 1'b0);
    end
    set_act(d, 1'b1);
    tick(n);
    set_act(d, 1'b0);
    tick(gap);
  endtask

  task automatic direct(input string name, input logic [5:0] got);
    tests++;
    if (got !== 6'b0) begin
      fails++;
      $display("FAIL %s got %b, required 000000", name, got);
    end
  endtask

  initial begin
    int s;
    reset = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick(5);
    direct("reset_state_a", {pressed_a, press_a, release_a, short_a, long_a, repeat_a});
    direct("reset_state_b", {pressed_b, press_b, release_b, short_b, long_b, repeat_b});

    reset = 1'b0;
    tick(20);
    direct("held_through_reset_a", {pressed_a, press_a, release_a, short_a, long_a, repeat_a});

    set_act(0, 1'b0);
    tick(2);
    hold(0, 3, 3);

    hold(1, 4, 3);
    hold(1, 20, 3);
    hold(1, L, 1);
    hold(1, 3, 3);

    // One-cycle reset while in LONG: pressed drops with no release pulse.
    s = cyc;
    push(1, s + 1, EV_PRESS, 1'b1);
    push(1, s + 1 + L, EV_LONG, 1'b1);
    push(1, s + 11, 5'b0, 1'b0);
    set_act(1, 1'b1);
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    set_act(1, 1'b0);
    tick(2);
    hold(1, 3, 3);

    tick(5);
    tests++;
    if (qa.size() != 0) begin
      fails++;
      $display("FAIL missing_events dut0 got %0d pending, required 0", qa.size());
    end
    tests++;
    if (qb.size() != 0) begin
      fails++;
      $display("FAIL missing_events dut1 got %0d pending, required 0", qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
